// File: rtl/sl_channel_scheduler.sv
// Core-side sequencer between the CDC command/response FIFOs and the SL
// transceiver instances (receiver/transmitter pair per channel).
module sl_channel_scheduler #(
   parameter int unsigned CHANNEL_COUNT = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          cmd_empty,
   input  logic [33:0]                   cmd_data,
   output logic                          cmd_inc,
   input  logic                          rsp_full,
   output logic [33:0]                   rsp_data,
   output logic                          rsp_inc,
   output logic [2*CHANNEL_COUNT-1:0]    inst_wr_valid,
   output logic [1:0]                    inst_wr_mod,
   output logic [31:0]                   inst_wr_data,
   input  logic [2*CHANNEL_COUNT-1:0]    inst_wr_ready,
   input  logic [2*CHANNEL_COUNT-1:0]    inst_rsp_req,
   input  logic [2*CHANNEL_COUNT*34-1:0] inst_rsp_data,
   output logic [2*CHANNEL_COUNT-1:0]    inst_rsp_ack,
   output logic [5:0]                    sel_inst,
   output logic [7:0]                    drop_cnt
);

   localparam int unsigned INST_COUNT = 2 * CHANNEL_COUNT;

   typedef enum logic [1:0] {C_IDLE, C_POP, C_ISSUE} cstate_t;
   typedef enum logic [2:0] {R_IDLE, R_TAG, R_WAIT_T, R_DATA, R_WAIT_D} rstate_t;

   cstate_t                 c_state_q, c_state_d;
   logic [33:0]             cmd_q, cmd_d;
   logic [5:0]              sel_q, sel_d;
   logic [7:0]              drop_q, drop_d;
   logic                    cmd_inc_q, cmd_inc_d;
   logic [INST_COUNT-1:0]   wr_valid_q, wr_valid_d;
   logic [1:0]              wr_mod_q, wr_mod_d;
   logic [31:0]             wr_data_q, wr_data_d;

   rstate_t                 r_state_q, r_state_d;
   logic [5:0]              rr_q, rr_d;
   logic [5:0]              g_q, g_d;
   logic [5:0]              last_q, last_d;
   logic                    tag_valid_q, tag_valid_d;
   logic [33:0]             word_q, word_d;
   logic                    rsp_inc_q, rsp_inc_d;
   logic [33:0]             rsp_data_q, rsp_data_d;
   logic [INST_COUNT-1:0]   ack_q, ack_d;

   logic [INST_COUNT-1:0]   sel_onehot;
   logic [INST_COUNT-1:0]   g_onehot;
   logic                    sel_in_range;
   logic                    sel_ready;
   logic [INST_COUNT-1:0]   req_rot;
   int unsigned             rr_start;
   int unsigned             rr_off;
   logic [5:0]              gnt;
   logic [33:0]             gnt_word;

   assign cmd_inc       = cmd_inc_q;
   assign rsp_inc       = rsp_inc_q;
   assign rsp_data      = rsp_data_q;
   assign inst_wr_valid = wr_valid_q;
   assign inst_wr_mod   = wr_mod_q;
   assign inst_wr_data  = wr_data_q;
   assign inst_rsp_ack  = ack_q;
   assign sel_inst      = sel_q;
   assign drop_cnt      = drop_q;

   // Decode selected and granted instance indices into one-hot vectors.
   always_comb begin
      sel_onehot = '0;
      g_onehot   = '0;
      for (int unsigned i = 0; i < INST_COUNT; i++) begin
         sel_onehot[i] = ({26'd0, sel_q} == i);
         g_onehot[i]   = ({26'd0, g_q} == i);
      end
      sel_in_range = ({26'd0, sel_q} < INST_COUNT);
      sel_ready    = |(inst_wr_ready & sel_onehot);
   end

   // Round-robin search: rotate requests so bit 0 is the instance after rr_q,
   // take the lowest set bit, then rotate the offset back to an index.
   always_comb begin
      logic found;
      found    = 1'b0;
      rr_off   = 0;
      gnt_word = '0;
      rr_start = ({26'd0, rr_q} + 1) % INST_COUNT;
      req_rot  = INST_COUNT'({inst_rsp_req, inst_rsp_req} >> rr_start);
      for (int unsigned k = 0; k < INST_COUNT; k++) begin
         if (!found && req_rot[k]) begin
            found  = 1'b1;
            rr_off = k;
         end
      end
      gnt = 6'((rr_start + rr_off) % INST_COUNT);
      for (int unsigned i = 0; i < INST_COUNT; i++) begin
         if ({26'd0, gnt} == i) gnt_word = inst_rsp_data[34*i +: 34];
      end
   end

   // Command FSM: pop, decode modifier, issue config/data to selected instance.
   always_comb begin
      c_state_d  = c_state_q;
      cmd_d      = cmd_q;
      sel_d      = sel_q;
      drop_d     = drop_q;
      cmd_inc_d  = 1'b0;
      wr_valid_d = '0;
      wr_mod_d   = '0;
      wr_data_d  = '0;
      case (c_state_q)
         C_IDLE: begin
            if (!cmd_empty) begin
               cmd_d     = cmd_data;
               cmd_inc_d = 1'b1;
               c_state_d = C_POP;
            end
         end
         C_POP: begin
            c_state_d = C_IDLE;
            case (cmd_q[33:32])
               2'd3: sel_d = cmd_q[5:0];
               2'd2: ;
               default: begin
                  if (!sel_in_range) begin
                     if (drop_q != '1) drop_d = drop_q + 8'd1;
                  end else begin
                     c_state_d  = C_ISSUE;
                     wr_valid_d = sel_onehot;
                     wr_mod_d   = cmd_q[33:32];
                     wr_data_d  = cmd_q[31:0];
                  end
               end
            endcase
         end
         C_ISSUE: begin
            if (sel_ready) begin
               c_state_d = C_IDLE;
            end else begin
               wr_valid_d = wr_valid_q;
               wr_mod_d   = wr_mod_q;
               wr_data_d  = wr_data_q;
            end
         end
         default: c_state_d = C_IDLE;
      endcase
   end

   // Response FSM: arbitrate, insert source tag on change, push word and ack.
   always_comb begin
      r_state_d   = r_state_q;
      rr_d        = rr_q;
      g_d         = g_q;
      last_d      = last_q;
      tag_valid_d = tag_valid_q;
      word_d      = word_q;
      rsp_inc_d   = 1'b0;
      rsp_data_d  = rsp_data_q;
      ack_d       = '0;
      case (r_state_q)
         R_IDLE: begin
            if ((|inst_rsp_req) && !rsp_full) begin
               g_d       = gnt;
               rr_d      = gnt;
               word_d    = gnt_word;
               r_state_d = (!tag_valid_q || gnt != last_q) ? R_TAG : R_DATA;
            end
         end
         R_TAG: begin
            if (!rsp_full) begin
               rsp_inc_d   = 1'b1;
               rsp_data_d  = {2'd3, 26'd0, g_q};
               last_d      = g_q;
               tag_valid_d = 1'b1;
               r_state_d   = R_WAIT_T;
            end
         end
         R_WAIT_T: r_state_d = R_DATA;
         R_DATA: begin
            if (!rsp_full) begin
               rsp_inc_d  = 1'b1;
               rsp_data_d = word_q;
               ack_d      = g_onehot;
               r_state_d  = R_WAIT_D;
            end
         end
         R_WAIT_D: r_state_d = R_IDLE;
         default:  r_state_d = R_IDLE;
      endcase
   end

   // State and registered outputs for both FSMs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         c_state_q   <= C_IDLE;
         cmd_q       <= '0;
         sel_q       <= '0;
         drop_q      <= '0;
         cmd_inc_q   <= 1'b0;
         wr_valid_q  <= '0;
         wr_mod_q    <= '0;
         wr_data_q   <= '0;
         r_state_q   <= R_IDLE;
         rr_q        <= 6'(INST_COUNT - 1);
         g_q         <= '0;
         last_q      <= '0;
         tag_valid_q <= 1'b0;
         word_q      <= '0;
         rsp_inc_q   <= 1'b0;
         rsp_data_q  <= '0;
         ack_q       <= '0;
      end else begin
         c_state_q   <= c_state_d;
         cmd_q       <= cmd_d;
         sel_q       <= sel_d;
         drop_q      <= drop_d;
         cmd_inc_q   <= cmd_inc_d;
         wr_valid_q  <= wr_valid_d;
         wr_mod_q    <= wr_mod_d;
         wr_data_q   <= wr_data_d;
         r_state_q   <= r_state_d;
         rr_q        <= rr_d;
         g_q         <= g_d;
         last_q      <= last_d;
         tag_valid_q <= tag_valid_d;
         word_q      <= word_d;
         rsp_inc_q   <= rsp_inc_d;
         rsp_data_q  <= rsp_data_d;
         ack_q       <= ack_d;
      end
   end

endmodule

// File: tb/tb_sl_channel_scheduler.sv
// Directed bench for sl_channel_scheduler with two channels (four instances).
module tb_sl_channel_scheduler;

   localparam logic [33:0] W0  = {2'd1, 32'hA000_0000};
   localparam logic [33:0] W2  = {2'd0, 32'h2222_0002};
   localparam logic [33:0] W1A = {2'd2, 32'h1111_000A};
   localparam logic [33:0] W1B = {2'd1, 32'h1111_000B};
   localparam logic [33:0] W1C = {2'd0, 32'h1111_000C};
   localparam logic [33:0] W3  = {2'd3, 32'h3333_0003};

   typedef struct {
      logic [1:0]  m;
      logic [31:0] p;
      int unsigned dly;
      logic [3:0]  ev;
      int unsigned ecyc;
      logic [1:0]  em;
      logic [31:0] ed;
      logic [5:0]  esel;
      logic [7:0]  edrop;
   } cvec_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cmd_empty = 1'b1;
   logic [33:0]   cmd_data = '0;
   logic          cmd_inc;
   logic          rsp_full = 1'b0;
   logic [33:0]   rsp_data;
   logic          rsp_inc;
   logic [3:0]    inst_wr_valid;
   logic [1:0]    inst_wr_mod;
   logic [31:0]   inst_wr_data;
   logic [3:0]    inst_wr_ready = '0;
   logic [3:0]    inst_rsp_req = '0;
   logic [135:0]  inst_rsp_data = '0;
   logic [3:0]    inst_rsp_ack;
   logic [5:0]    sel_inst;
   logic [7:0]    drop_cnt;

   // Command FIFO model (producer: stimulus, consumer: monitor).
   logic [33:0]   cmem [1024];
   int unsigned   cwr = 0;
   int unsigned   crd = 0;
   // Per-instance response word stores.
   logic [33:0]   iw [4][16];
   int unsigned   iwr [4] = '{default: 0};
   int unsigned   ird [4] = '{default: 0};
   // Captured response FIFO pushes and acks.
   logic [33:0]   cap [512];
   int unsigned   capn = 0;
   logic [3:0]    ackl [512];
   int unsigned   ackn = 0;
   int unsigned   cmd_pulses = 0;
   int unsigned   adj_cmd = 0;
   int unsigned   adj_rsp = 0;
   logic          prev_ci = 1'b0;
   logic          prev_ri = 1'b0;

   int unsigned   errors = 0;
   int unsigned   checks = 0;

   sl_channel_scheduler #(.CHANNEL_COUNT(2)) dut (
      .clk           (clk),
      .rst           (rst),
      .cmd_empty     (cmd_empty),
      .cmd_data      (cmd_data),
      .cmd_inc       (cmd_inc),
      .rsp_full      (rsp_full),
      .rsp_data      (rsp_data),
      .rsp_inc       (rsp_inc),
      .inst_wr_valid (inst_wr_valid),
      .inst_wr_mod   (inst_wr_mod),
      .inst_wr_data  (inst_wr_data),
      .inst_wr_ready (inst_wr_ready),
      .inst_rsp_req  (inst_rsp_req),
      .inst_rsp_data (inst_rsp_data),
      .inst_rsp_ack  (inst_rsp_ack),
      .sel_inst      (sel_inst),
      .drop_cnt      (drop_cnt)
   );

   always #5 clk = ~clk;

   // Sample DUT pulses at the active edge (values from the cycle just ended).
   always @(posedge clk) begin
      if (cmd_inc) begin
         cmd_pulses <= cmd_pulses + 1;
         if (crd != cwr) crd <= crd + 1;
      end
      if (cmd_inc && prev_ci) adj_cmd <= adj_cmd + 1;
      if (rsp_inc && prev_ri) adj_rsp <= adj_rsp + 1;
      prev_ci <= cmd_inc;
      prev_ri <= rsp_inc;
      if (rsp_inc) begin
         cap[capn % 512] <= rsp_data;
         capn <= capn + 1;
      end
      if (inst_rsp_ack != 4'd0) begin
         ackl[ackn % 512] <= inst_rsp_ack;
         ackn <= ackn + 1;
         for (int i = 0; i < 4; i++)
            if (inst_rsp_ack[i] && ird[i] != iwr[i]) ird[i] <= ird[i] + 1;
      end
   end

   // FIFO flags and instance request lines update away from the active edge.
   always @(negedge clk) begin
      cmd_empty <= (cwr == crd);
      cmd_data  <= cmem[crd % 1024];
      for (int i = 0; i < 4; i++) begin
         inst_rsp_req[i]          <= (iwr[i] != ird[i]);
         inst_rsp_data[34*i +: 34] <= iw[i][ird[i] % 16];
      end
   end

   function automatic logic [33:0] tag(input int unsigned i);
      return {2'd3, 26'd0, 6'(i)};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_outputs_zero(input string nm);
      chk({nm, " cmd_inc"},       64'(cmd_inc), 64'd0);
      chk({nm, " rsp_inc"},       64'(rsp_inc), 64'd0);
      chk({nm, " rsp_data"},      64'(rsp_data), 64'd0);
      chk({nm, " inst_wr_valid"}, 64'(inst_wr_valid), 64'd0);
      chk({nm, " inst_wr_mod"},   64'(inst_wr_mod), 64'd0);
      chk({nm, " inst_wr_data"},  64'(inst_wr_data), 64'd0);
      chk({nm, " inst_rsp_ack"},  64'(inst_rsp_ack), 64'd0);
      chk({nm, " sel_inst"},      64'(sel_inst), 64'd0);
      chk({nm, " drop_cnt"},      64'(drop_cnt), 64'd0);
   endtask

   task automatic push_cmd(input logic [1:0] m, input logic [31:0] p);
      cmem[cwr % 1024] = {m, p};
      cwr++;
   endtask

   task automatic push_word(input int unsigned i, input logic [33:0] w);
      iw[i][iwr[i] % 16] = w;
      iwr[i]++;
   endtask

   task automatic wait_cap(input int unsigned base, input int unsigned n, input int unsigned maxc);
      for (int unsigned c = 0; c < maxc; c++) begin
         if (capn - base >= n) break;
         @(negedge clk);
      end
      repeat (10) @(negedge clk);
   endtask

   // Non-selected ready bits are driven high while waiting, to show they are ignored.
   task automatic run_cmd(input logic [1:0] m, input logic [31:0] p, input int unsigned dly,
                          output logic [3:0] v_seen, output int unsigned v_cyc,
                          output logic [1:0] m_seen, output logic [31:0] d_seen,
                          output int unsigned pulses);
      int unsigned p0;
      p0     = cmd_pulses;
      v_seen = '0;
      v_cyc  = 0;
      m_seen = '0;
      d_seen = '0;
      push_cmd(m, p);
      for (int unsigned c = 0; c < dly + 8; c++) begin
         @(negedge clk);
         if (inst_wr_valid != 4'd0) begin
            v_seen |= inst_wr_valid;
            v_cyc++;
            m_seen = inst_wr_mod;
            d_seen = inst_wr_data;
            inst_wr_ready = (v_cyc == dly + 1) ? 4'hF : ~inst_wr_valid;
         end else begin
            inst_wr_ready = 4'h0;
         end
      end
      pulses = cmd_pulses - p0;
   endtask

   initial begin
      cvec_t       tbl [13];
      logic [33:0] rexp [6];
      logic [3:0]  aexp [3];
      logic [3:0]  v_seen;
      int unsigned v_cyc;
      logic [1:0]  m_seen;
      logic [31:0] d_seen;
      int unsigned pulses;
      int unsigned capb;
      int unsigned ackb;
      int unsigned cnt_i;
      int unsigned cnt_a;

      tbl[0]  = '{m:2'd3, p:32'h1,        dly:0, ev:4'h0, ecyc:0, em:2'd0, ed:32'h0,        esel:6'd1,  edrop:8'd0};
      tbl[1]  = '{m:2'd0, p:32'h1234,     dly:3, ev:4'h2, ecyc:4, em:2'd0, ed:32'h1234,     esel:6'd1,  edrop:8'd0};
      tbl[2]  = '{m:2'd3, p:32'h9,        dly:0, ev:4'h0, ecyc:0, em:2'd0, ed:32'h0,        esel:6'd9,  edrop:8'd0};
      tbl[3]  = '{m:2'd1, p:32'hAA,       dly:0, ev:4'h0, ecyc:0, em:2'd0, ed:32'h0,        esel:6'd9,  edrop:8'd1};
      tbl[4]  = '{m:2'd2, p:32'h5,        dly:0, ev:4'h0, ecyc:0, em:2'd0, ed:32'h0,        esel:6'd9,  edrop:8'd1};
      tbl[5]  = '{m:2'd3, p:32'h3,        dly:0, ev:4'h0, ecyc:0, em:2'd0, ed:32'h0,        esel:6'd3,  edrop:8'd1};
      tbl[6]  = '{m:2'd1, p:32'hDEADBEEF, dly:0, ev:4'h8, ecyc:1, em:2'd1, ed:32'hDEADBEEF, esel:6'd3,  edrop:8'd1};
      tbl[7]  = '{m:2'd3, p:32'h2,        dly:0, ev:4'h0, ecyc:0, em:2'd0, ed:32'h0,        esel:6'd2,  edrop:8'd1};
      tbl[8]  = '{m:2'd2, p:32'h77,       dly:0, ev:4'h0, ecyc:0, em:2'd0, ed:32'h0,        esel:6'd2,  edrop:8'd1};
      tbl[9]  = '{m:2'd0, p:32'hCAFE,     dly:1, ev:4'h4, ecyc:2, em:2'd0, ed:32'hCAFE,     esel:6'd2,  edrop:8'd1};
      tbl[10] = '{m:2'd3, p:32'h4,        dly:0, ev:4'h0, ecyc:0, em:2'd0, ed:32'h0,        esel:6'd4,  edrop:8'd1};
      tbl[11] = '{m:2'd0, p:32'h1,        dly:0, ev:4'h0, ecyc:0, em:2'd0, ed:32'h0,        esel:6'd4,  edrop:8'd2};
      tbl[12] = '{m:2'd3, p:32'h43,       dly:0, ev:4'h0, ecyc:0, em:2'd0, ed:32'h0,        esel:6'd3,  edrop:8'd2};

      // Reset state
      repeat (2) @(negedge clk);
      chk_outputs_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      // Command vectors
      for (int i = 0; i < 13; i++) begin
         run_cmd(tbl[i].m, tbl[i].p, tbl[i].dly, v_seen, v_cyc, m_seen, d_seen, pulses);
         chk($sformatf("vec%0d valid", i),    64'(v_seen), 64'(tbl[i].ev));
         chk($sformatf("vec%0d vcycles", i),  64'(v_cyc), 64'(tbl[i].ecyc));
         chk($sformatf("vec%0d sel", i),      64'(sel_inst), 64'(tbl[i].esel));
         chk($sformatf("vec%0d drop", i),     64'(drop_cnt), 64'(tbl[i].edrop));
         chk($sformatf("vec%0d cmd_inc", i),  64'(pulses), 64'd1);
         if (tbl[i].ev != 4'd0) begin
            chk($sformatf("vec%0d mod", i),  64'(m_seen), 64'(tbl[i].em));
            chk($sformatf("vec%0d data", i), 64'(d_seen), 64'(tbl[i].ed));
         end
      end

      // Drop counter saturation
      push_cmd(2'd3, 32'h3F);
      for (int unsigned k = 0; k < 300; k++) push_cmd(2'd1, k);
      for (int unsigned c = 0; c < 2000; c++) begin
         if (crd == cwr) break;
         @(negedge clk);
      end
      repeat (4) @(negedge clk);
      chk("sat drained", 64'(cwr - crd), 64'd0);
      chk("sat drop_cnt", 64'(drop_cnt), 64'd255);
      chk("sat sel", 64'(sel_inst), 64'd63);

      // Round-robin between instances 0 and 2
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      capb = capn;
      ackb = ackn;
      push_word(0, W0);
      push_word(0, W0);
      push_word(2, W2);
      rexp = '{tag(0), W0, tag(2), W2, tag(0), W0};
      aexp = '{4'b0001, 4'b0100, 4'b0001};
      wait_cap(capb, 6, 200);
      chk("rr count", 64'(capn - capb), 64'd6);
      for (int unsigned k = 0; k < 6; k++)
         chk($sformatf("rr word%0d", k), 64'(cap[(capb + k) % 512]), 64'(rexp[k]));
      chk("rr ack count", 64'(ackn - ackb), 64'd3);
      for (int unsigned k = 0; k < 3; k++)
         chk($sformatf("rr ack%0d", k), 64'(ackl[(ackb + k) % 512]), 64'(aexp[k]));

      // Back-to-back words from one instance share one tag
      capb = capn;
      ackb = ackn;
      push_word(1, W1A);
      push_word(1, W1B);
      wait_cap(capb, 3, 200);
      chk("same count", 64'(capn - capb), 64'd3);
      chk("same word0", 64'(cap[capb % 512]), 64'(tag(1)));
      chk("same word1", 64'(cap[(capb + 1) % 512]), 64'(W1A));
      chk("same word2", 64'(cap[(capb + 2) % 512]), 64'(W1B));
      chk("same acks", 64'(ackn - ackb), 64'd2);

      // Response FIFO full holds everything
      rsp_full = 1'b1;
      capb = capn;
      push_word(3, W3);
      cnt_i = 0;
      cnt_a = 0;
      repeat (10) begin
         @(negedge clk);
         if (rsp_inc) cnt_i++;
         if (inst_rsp_ack != 4'd0) cnt_a++;
      end
      chk("full rsp_inc", 64'(cnt_i), 64'd0);
      chk("full ack", 64'(cnt_a), 64'd0);
      rsp_full = 1'b0;
      @(negedge clk);
      chk("full rel+1 rsp_inc", 64'(rsp_inc), 64'd0);
      @(negedge clk);
      chk("full rel+2 rsp_inc", 64'(rsp_inc), 64'd1);
      chk("full rel+2 tag", 64'(rsp_data), 64'(tag(3)));
      wait_cap(capb, 2, 100);
      chk("full count", 64'(capn - capb), 64'd2);
      chk("full word", 64'(cap[(capb + 1) % 512]), 64'(W3));

      // Reset while issuing and while holding in R_DATA
      inst_wr_ready = 4'h0;
      push_cmd(2'd3, 32'h1);
      push_cmd(2'd0, 32'h55);
      push_word(1, W1C);
      for (int unsigned c = 0; c < 30; c++) begin
         @(negedge clk);
         if (rsp_inc) break;
      end
      chk("mid tag seen", 64'(rsp_inc), 64'd1);
      chk("mid tag value", 64'(rsp_data), 64'(tag(1)));
      rsp_full = 1'b1;
      ackb = ackn;
      cnt_i = 0;
      repeat (6) begin
         @(negedge clk);
         if (rsp_inc) cnt_i++;
      end
      chk("mid held rsp_inc", 64'(cnt_i), 64'd0);
      chk("mid valid", 64'(inst_wr_valid), 64'h2);
      chk("mid data", 64'(inst_wr_data), 64'h55);
      rst = 1'b1;
      @(negedge clk);
      chk_outputs_zero("midrst");
      chk("midrst no ack", 64'(ackn - ackb), 64'd0);
      chk("midrst word kept", 64'(iwr[1] - ird[1]), 64'd1);
      rst = 1'b0;
      rsp_full = 1'b0;
      capb = capn;
      wait_cap(capb, 2, 100);
      chk("post count", 64'(capn - capb), 64'd2);
      chk("post tag", 64'(cap[capb % 512]), 64'(tag(1)));
      chk("post word", 64'(cap[(capb + 1) % 512]), 64'(W1C));
      chk("post valid", 64'(inst_wr_valid), 64'd0);

      chk("cmd_inc adjacent", 64'(adj_cmd), 64'd0);
      chk("rsp_inc adjacent", 64'(adj_rsp), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
